// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the ROM port arbiter: port indices, response tag and
// default bus widths matching the instruction/constant ROM.
package rom_port_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 16;
  localparam int unsigned DefaultDataW = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LD = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from the request pair and a
// priority pointer that moves only when something is granted.
module rr_arbiter2
  import rom_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || ptr_q == PORT_IF)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  // The pointer always moves to the port that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = PORT_LD;
    end else if (gnt[1]) begin
      ptr_d = PORT_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= PORT_IF;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-ported registered ROM between instruction fetch and the
// load unit, with address checks and a fixed one-cycle response.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefaultAddrW,
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned ROM_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ready,
  output logic              ld_rsp_valid,
  output logic [DATA_W-1:0] ld_rsp_data,
  output logic              ld_rsp_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              gnt_port;
  logic [ADDR_W-1:0] gnt_addr;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              gnt_err;
  rsp_tag_t          tag_d, tag_q;
  logic              rsp_live;

  // Holding requests off during reset keeps ready and rom_ce low.
  assign req = {ld_req_valid, if_req_valid} & {2{rst_n}};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    gnt_any      = |gnt;
    gnt_port     = gnt[1] ? PORT_LD : PORT_IF;
    gnt_addr     = gnt[1] ? ld_req_addr : if_req_addr;
    word_idx     = gnt_addr >> 2;
    misaligned   = gnt_addr[1:0] != 2'b00;
    out_of_range = 32'(word_idx) >= ROM_WORDS;
    gnt_err      = misaligned | out_of_range;
  end

  assign if_req_ready = gnt[0];
  assign ld_req_ready = gnt[1];
  assign rom_ce       = gnt_any & ~gnt_err;
  assign rom_addr     = rom_ce ? gnt_addr : '0;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = gnt_any;
    tag_d.port  = gnt_port;
    tag_d.err   = gnt_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // A response whose cycle overlaps reset is dropped; the requester re-issues.
  assign rsp_live = tag_q.valid & rst_n;

  assign if_rsp_valid = rsp_live & (tag_q.port == PORT_IF);
  assign ld_rsp_valid = rsp_live & (tag_q.port == PORT_LD);
  assign if_rsp_err   = if_rsp_valid & tag_q.err;
  assign ld_rsp_err   = ld_rsp_valid & tag_q.err;
  assign if_rsp_data  = (if_rsp_valid & ~tag_q.err) ? rom_dout : '0;
  assign ld_rsp_data  = (ld_rsp_valid & ~tag_q.err) ? rom_dout : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a small ROM model and a per-cycle
// reference model of arbitration, address checks and response timing.
module tb_rom_port_arbiter;

  localparam int unsigned ROM_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_v, ld_v;
  logic [15:0] if_a, ld_a;
  logic        if_req_ready, ld_req_ready;
  logic        if_rsp_valid, ld_rsp_valid;
  logic [31:0] if_rsp_data, ld_rsp_data;
  logic        if_rsp_err, ld_rsp_err;
  logic        rom_ce;
  logic [15:0] rom_addr;
  logic [31:0] rom_dout = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .ROM_WORDS (ROM_WORDS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_v),
    .if_req_addr  (if_a),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ld_req_valid (ld_v),
    .ld_req_addr  (ld_a),
    .ld_req_ready (ld_req_ready),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .ld_rsp_err   (ld_rsp_err),
    .rom_ce       (rom_ce),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout)
  );

  // ROM preload: mem[i] = i << 8, registered output.
  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return 32'(a >> 2) << 8;
  endfunction

  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom_word(rom_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_live = 1'b0;
  bit          m_prio = 1'b0;  // 0 = IF, 1 = LD
  bit          p_valid = 1'b0;
  bit          p_port, p_err;
  logic [31:0] p_data;

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (if_v && ld_v) return m_prio ? 1 : 0;
    if (if_v) return 0;
    if (ld_v) return 1;
    return -1;
  endfunction

  function automatic bit bad_addr(input logic [15:0] a);
    return (a[1:0] != 2'b00) || (int'(a >> 2) >= int'(ROM_WORDS));
  endfunction

  always @(posedge clk) begin : model
    int          g;
    logic [15:0] a;
    g = exp_grant();
    if (!rst_n) begin
      m_prio  = 1'b0;
      p_valid = 1'b0;
    end else if (g >= 0) begin
      a       = (g == 1) ? ld_a : if_a;
      p_valid = 1'b1;
      p_port  = (g == 1);
      p_err   = bad_addr(a);
      p_data  = p_err ? 32'h0 : rom_word(a);
      m_prio  = (g == 0);
    end else begin
      p_valid = 1'b0;
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin : compare
    int          g;
    logic [15:0] a;
    bit          e, ce, ev_if, ev_ld;
    if (m_live) begin
      g  = exp_grant();
      a  = (g == 1) ? ld_a : ((g == 0) ? if_a : 16'h0);
      e  = (g >= 0) && bad_addr(a);
      ce = (g >= 0) && !e;
      check("if_req_ready", {31'b0, if_req_ready}, {31'b0, g == 0});
      check("ld_req_ready", {31'b0, ld_req_ready}, {31'b0, g == 1});
      check("rom_ce", {31'b0, rom_ce}, {31'b0, ce});
      check("rom_addr", {16'b0, rom_addr}, ce ? {16'b0, a} : 32'h0);
      ev_if = rst_n && p_valid && !p_port;
      ev_ld = rst_n && p_valid && p_port;
      check("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, ev_if});
      check("ld_rsp_valid", {31'b0, ld_rsp_valid}, {31'b0, ev_ld});
      if (ev_if) begin
        check("if_rsp_data", if_rsp_data, p_data);
        check("if_rsp_err", {31'b0, if_rsp_err}, {31'b0, p_err});
      end
      if (ev_ld) begin
        check("ld_rsp_data", ld_rsp_data, p_data);
        check("ld_rsp_err", {31'b0, ld_rsp_err}, {31'b0, p_err});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ia,
                       input logic lv, input logic [15:0] la);
    if_v = iv;
    if_a = ia;
    ld_v = lv;
    ld_a = la;
  endtask

  initial begin
    // 1. reset with both valids high
    rst_n = 1'b0;
    drive(1'b1, 16'h0004, 1'b1, 16'h0008);
    @(negedge clk);
    check("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
    check("rst_ld_ready", {31'b0, ld_req_ready}, 32'd0);
    check("rst_rom_ce", {31'b0, rom_ce}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
    check("rst_ld_rsp_valid", {31'b0, ld_rsp_valid}, 32'd0);
    check("rst_if_rsp_data", if_rsp_data, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_if", {31'b0, if_req_ready}, 32'd1);
    check("first_grant_ld", {31'b0, ld_req_ready}, 32'd0);
    cyc();

    // 2. IF only, addr 0x0004
    drive(1'b1, 16'h0004, 1'b0, 16'h0000);
    @(negedge clk);
    check("t2_ready", {31'b0, if_req_ready}, 32'd1);
    check("t2_rom_ce", {31'b0, rom_ce}, 32'd1);
    check("t2_rom_addr", {16'b0, rom_addr}, 32'h0004);
    cyc();
    // LD-only grant here leaves the pointer at IF for the next phase
    drive(1'b0, 16'h0000, 1'b1, 16'h000C);
    @(negedge clk);
    check("t2_rsp_valid", {31'b0, if_rsp_valid}, 32'd1);
    check("t2_rsp_data", if_rsp_data, 32'h0000_0100);
    check("t2_rsp_err", {31'b0, if_rsp_err}, 32'd0);
    check("t2_ld_rsp_valid", {31'b0, ld_rsp_valid}, 32'd0);
    cyc();

    // 3. both valid for four cycles: IF, LD, IF, LD
    drive(1'b1, 16'h0008, 1'b1, 16'h000C);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_if_ready", {31'b0, if_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_ld_ready", {31'b0, ld_req_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 1) check("t3_if_data", if_rsp_data, 32'h0000_0200);
      if (k == 2) check("t3_ld_data", ld_rsp_data, 32'h0000_0300);
      if (k == 3) check("t3_if_data2", if_rsp_data, 32'h0000_0200);
      cyc();
    end

    // 4. LD misaligned, then LD out of range
    drive(1'b0, 16'h0000, 1'b1, 16'h0006);
    @(negedge clk);
    check("t4a_ready", {31'b0, ld_req_ready}, 32'd1);
    check("t4a_rom_ce", {31'b0, rom_ce}, 32'd0);
    check("t4_prev_ld_data", ld_rsp_data, 32'h0000_0300);
    cyc();
    drive(1'b0, 16'h0000, 1'b1, 16'h0040);
    @(negedge clk);
    check("t4a_rsp_err", {31'b0, ld_rsp_err}, 32'd1);
    check("t4a_rsp_data", ld_rsp_data, 32'd0);
    check("t4b_ready", {31'b0, ld_req_ready}, 32'd1);
    check("t4b_rom_ce", {31'b0, rom_ce}, 32'd0);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    check("t4b_rsp_valid", {31'b0, ld_rsp_valid}, 32'd1);
    check("t4b_rsp_err", {31'b0, ld_rsp_err}, 32'd1);
    check("t4b_if_idle", {31'b0, if_rsp_valid}, 32'd0);
    cyc();

    // 5. grant then reset before the response cycle
    drive(1'b1, 16'h0004, 1'b0, 16'h0000);
    @(negedge clk);
    check("t5_ready", {31'b0, if_req_ready}, 32'd1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_no_rsp", {31'b0, if_rsp_valid}, 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_rsp_after", {31'b0, if_rsp_valid}, 32'd0);
    cyc();
    drive(1'b1, 16'h0004, 1'b0, 16'h0000);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    check("t5_reissue_valid", {31'b0, if_rsp_valid}, 32'd1);
    check("t5_reissue_data", if_rsp_data, 32'h0000_0100);
    cyc();

    // 6. LD grant, three idle cycles, then both valid
    drive(1'b0, 16'h0000, 1'b1, 16'h0008);
    @(negedge clk);
    check("t6_ld_ready", {31'b0, ld_req_ready}, 32'd1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    cyc();
    cyc();
    cyc();
    drive(1'b1, 16'h0004, 1'b1, 16'h0008);
    @(negedge clk);
    check("t6_if_first", {31'b0, if_req_ready}, 32'd1);
    check("t6_ld_wait", {31'b0, ld_req_ready}, 32'd0);
    cyc();
    @(negedge clk);
    check("t6_ld_next", {31'b0, ld_req_ready}, 32'd1);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
